// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl
//   IF-stage fetch controller. It owns the program counter, drives the
//   synchronous-read instruction memory, and tags each returned word with the
//   PC it was fetched from. It absorbs the one-cycle imem latency, downstream
//   stalls (through a one-entry hold buffer) and redirects coming from EX.
//
// Ports
//   clk          pipeline clock, rising edge
//   rst          synchronous active-high reset (same net as imem rst)
//   stall        downstream cannot take this cycle's if_* outputs
//   redirect_en  taken branch/jump from EX, beats sequential fetch and stall
//   redirect_pc  redirect target; the low two bits are dropped
//   pc_out       address presented to imem (pc_q)
//   instr_in     imem word for the address presented on the previous edge
//   if_pc        PC of if_instr
//   if_pc4       if_pc + 4, 32-bit wrap
//   if_instr     instruction to IF/ID (don't-care while if_valid = 0)
//   if_valid     if_* carries a real instruction
//   state_dbg    FSM state: 0 = RUN, 1 = HOLD
//
// Handshake: a word is transferred to IF/ID on every cycle where
// if_valid = 1 and stall = 0. While stall = 1 the if_* outputs are held
// stable, and they stay stable through the release cycle.

module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        state_dbg
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] f_pc;
  logic        f_valid;
  logic [31:0] h_pc;
  logic [31:0] h_instr;
  logic        h_valid;
  logic        base_valid;

  always_ff @(posedge clk) begin
    // The word arriving next cycle always belongs to the address presented now.
    f_pc <= pc_q;

    if (rst) begin
      pc_q    <= RESET_PC;
      f_valid <= 1'b0;
      state   <= RUN;
      h_valid <= 1'b0;
    end else begin
      // A redirect makes the word already in flight from imem stale.
      f_valid <= ~redirect_en;

      if (redirect_en) begin
        pc_q <= {redirect_pc[31:2], 2'b00};
      end else if (!stall) begin
        pc_q <= pc_q + 32'd4;
      end

      case (state)
        RUN: begin
          if (redirect_en) begin
            h_valid <= 1'b0;
          end else if (stall) begin
            // imem will keep returning mem[pc_q] while pc_q holds, so the word
            // being presented now survives only in the hold buffer.
            h_pc    <= f_pc;
            h_instr <= instr_in;
            h_valid <= f_valid;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (redirect_en) begin
            h_valid <= 1'b0;
            state   <= RUN;
          end else if (!stall) begin
            // Held word is consumed this cycle; pc_q steps to N+4 and the
            // following RUN cycle presents mem[N] tagged N.
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    if_pc      = f_pc;
    if_instr   = instr_in;
    base_valid = f_valid;
    if (state == HOLD) begin
      if_pc      = h_pc;
      if_instr   = h_instr;
      base_valid = h_valid;
    end
  end

  // The redirect kills whatever is being presented in the same cycle.
  assign if_valid  = base_valid & ~redirect_en;
  assign if_pc4    = if_pc + 32'd4;
  assign pc_out    = pc_q;
  assign state_dbg = (state == HOLD);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        state_dbg;

  int checks;
  int failures;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .pc_out      (pc_out),
    .instr_in    (instr_in),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .state_dbg   (state_dbg)
  );

  // Instruction memory content: multiplication by an odd constant is a
  // bijection, so every address holds a distinct word.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Synchronous-read imem.
  always @(posedge clk) instr_in <= word_of(pc_out);

  // ---------------- reference model ----------------
  // Transaction view: m_pc is the next address to fetch (what pc_out shows),
  // m_valid/m_out_pc the instruction currently offered to IF/ID.
  logic [31:0] m_pc;
  logic [31:0] m_out_pc;
  logic        m_valid;
  logic [31:0] exp_q[$];

  task automatic model_update();
    if (rst) begin
      m_pc    = RESET_PC;
      m_valid = 1'b0;
    end else if (redirect_en) begin
      m_pc    = {redirect_pc[31:2], 2'b00};
      m_valid = 1'b0;
    end else if (!stall) begin
      m_out_pc = m_pc;
      m_valid  = 1'b1;
      m_pc     = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver ----------------
  // Advance one cycle, then apply new inputs at the falling edge; callers
  // compare the outputs of the new cycle right after this returns.
  task automatic drive(input logic r, input logic s, input logic re, input logic [31:0] tgt);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst         = r;
    stall       = s;
    redirect_en = re;
    redirect_pc = tgt;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b0 || pc_out !== RESET_PC || state_dbg !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d valid=%0b pc_out=%h state=%0b exp 0/%h/0", i, if_valid, pc_out, state_dbg, RESET_PC);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0 || pc_out !== RESET_PC) begin
      failures++;
      $display("FAIL reset_first valid=%0b pc_out=%h exp 0/%h", if_valid, pc_out, RESET_PC);
    end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] e;
      e = RESET_PC + 32'(4 * i);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e) || if_pc4 !== e + 32'd4 || pc_out !== e + 32'd4) begin
        failures++;
        $display("FAIL seq_fetch i=%0d valid=%0b pc=%h instr=%h pc4=%h pc_out=%h exp pc=%h instr=%h", i, if_valid, if_pc, if_instr, if_pc4, pc_out, e, word_of(e));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);  // if_pc 0
    drive(1'b0, 1'b0, 1'b0, 32'h0);  // if_pc 4
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, (i < 3), 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== word_of(32'h8) || pc_out !== 32'hC) begin
        failures++;
        $display("FAIL stall_hold i=%0d valid=%0b pc=%h instr=%h pc_out=%h exp 1/8/%h/c", i, if_valid, if_pc, if_instr, pc_out, word_of(32'h8));
      end
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== word_of(32'hC) || pc_out !== 32'h10 || state_dbg !== 1'b0) begin
      failures++;
      $display("FAIL stall_release valid=%0b pc=%h instr=%h pc_out=%h state=%0b exp 1/c/%h/10/0", if_valid, if_pc, if_instr, pc_out, state_dbg, word_of(32'hC));
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 32'h0);  // if_pc 0..C
    drive(1'b0, 1'b0, 1'b1, 32'h40);  // if_pc 0x10 killed
    checks++;
    if (if_valid !== 1'b0 || if_pc !== 32'h10) begin
      failures++;
      $display("FAIL redirect_kill valid=%0b pc=%h exp 0/10", if_valid, if_pc);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0 || pc_out !== 32'h40) begin
      failures++;
      $display("FAIL redirect_bubble valid=%0b pc_out=%h exp 0/40", if_valid, pc_out);
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = 32'h40 + 32'(4 * i);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e)) begin
        failures++;
        $display("FAIL redirect_target i=%0d valid=%0b pc=%h instr=%h exp pc=%h", i, if_valid, if_pc, if_instr, e);
      end
    end
  endtask

  task automatic test_redirect_in_hold();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);   // if_pc 8, stalled
    drive(1'b0, 1'b1, 1'b0, 32'h0);   // HOLD
    checks++;
    if (state_dbg !== 1'b1) begin
      failures++;
      $display("FAIL hold_entered state=%0b exp 1", state_dbg);
    end
    drive(1'b0, 1'b1, 1'b1, 32'h40);  // redirect with stall still high
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_redirect_kill valid=%0b exp 0", if_valid);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (state_dbg !== 1'b0 || pc_out !== 32'h40 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_redirect_run state=%0b pc_out=%h valid=%0b exp 0/40/0", state_dbg, pc_out, if_valid);
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = 32'h40 + 32'(4 * i);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e)) begin
        failures++;
        $display("FAIL hold_redirect_target i=%0d valid=%0b pc=%h exp %h", i, if_valid, if_pc, e);
      end
    end
  endtask

  task automatic test_misaligned_wrap();
    drive(1'b0, 1'b0, 1'b1, 32'h43);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (pc_out !== 32'h40) begin
      failures++;
      $display("FAIL misaligned pc_out=%h exp 40", pc_out);
    end
    drive(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_pc4 !== 32'h0 || pc_out !== 32'h0) begin
      failures++;
      $display("FAIL wrap_top valid=%0b pc=%h pc4=%h pc_out=%h exp 1/fffffffc/0/0", if_valid, if_pc, if_pc4, pc_out);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== word_of(32'h0)) begin
      failures++;
      $display("FAIL wrap_zero valid=%0b pc=%h instr=%h exp 1/0/%h", if_valid, if_pc, if_instr, word_of(32'h0));
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);   // HOLD with word 8
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (pc_out !== RESET_PC || if_valid !== 1'b0 || state_dbg !== 1'b0) begin
      failures++;
      $display("FAIL rst_hold pc_out=%h valid=%0b state=%0b exp %h/0/0", pc_out, if_valid, state_dbg, RESET_PC);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (if_valid !== 1'b0 || pc_out !== RESET_PC) begin
      failures++;
      $display("FAIL rst_hold_first valid=%0b pc_out=%h", if_valid, pc_out);
    end
    for (int i = 0; i < 2; i++) begin
      logic [31:0] e;
      e = RESET_PC + 32'(4 * i);
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      checks++;
      if (if_valid !== 1'b1 || if_pc !== e || if_instr !== word_of(e)) begin
        failures++;
        $display("FAIL rst_hold_restart i=%0d valid=%0b pc=%h instr=%h exp %h", i, if_valid, if_pc, if_instr, e);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    exp_q.delete();
    for (int n = 0; n < 600; n++) begin
      logic        r, s, re, ev;
      logic [31:0] t;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 9) < 3);
      re = ($urandom_range(0, 15) == 0);
      t  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 1023));
      drive(r, s, re, t);
      ev = m_valid & ~redirect_en;
      checks++;
      if (pc_out !== m_pc || if_valid !== ev) begin
        failures++;
        $display("FAIL rand_ctrl n=%0d pc_out=%h valid=%0b exp %h/%0b", n, pc_out, if_valid, m_pc, ev);
      end
      if (ev) begin
        checks++;
        if (if_pc !== m_out_pc || if_instr !== word_of(m_out_pc) || if_pc4 !== m_out_pc + 32'd4) begin
          failures++;
          $display("FAIL rand_data n=%0d pc=%h instr=%h pc4=%h exp pc=%h instr=%h", n, if_pc, if_instr, if_pc4, m_out_pc, word_of(m_out_pc));
        end
        if (!stall) exp_q.push_back(m_out_pc);
      end
      if (if_valid === 1'b1 && stall === 1'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_stream n=%0d unexpected pc=%h", n, if_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (if_pc !== e) begin
            failures++;
            $display("FAIL rand_stream n=%0d pc=%h exp %h", n, if_pc, e);
          end
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL rand_drain left=%0d exp 0", exp_q.size());
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    m_pc        = RESET_PC;
    m_out_pc    = RESET_PC;
    m_valid     = 1'b0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_misaligned_wrap();
    test_reset_mid_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch controller for the IF stage of the RV32IM pipeline. It owns the program counter, drives the address into the synchronous-read instruction memory, and tracks which PC the returned word belongs to. It presents a PC/instruction/valid triple to the IF/ID boundary. It absorbs the one-cycle imem read latency, downstream stalls (via a one-entry hold buffer) and branch/jump redirects from EX.

## Interface
- RESET_PC, 32'h0000_0000, PC presented to imem during and immediately after reset (word aligned)
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high; same net drives imem rst
- stall  in  1  downstream cannot accept this cycle's if_* outputs
- redirect_en  in  1  taken branch/jump from EX; overrides sequential fetch
- redirect_pc  in  32  redirect target
- pc_out  out  32  address to imem pc input (= pc_q, combinational from register)
- instr_in  in  32  imem instr output; word for the address presented on the previous edge
- if_pc  out  32  PC of if_instr
- if_pc4  out  32  if_pc + 4
- if_instr  out  32  instruction to IF/ID
- if_valid  out  1  if_* carries a real instruction

## Operation
- Registers:
  - pc_q: address being presented to imem.
  - f_pc, f_valid: tag for the word on instr_in.
  - state: RUN or HOLD.
  - h_pc, h_instr, h_valid: hold buffer.
- Tag update, every edge:
  - f_pc <= pc_q.
  - f_valid <= 1, except 0 when rst or redirect_en.
- pc_q update, priority highest first:
  - rst: pc_q <= RESET_PC.
  - redirect_en: pc_q <= {redirect_pc[31:2], 2'b00}.
  - stall: pc_q holds.
  - else: pc_q <= pc_q + 4, wrapping modulo 2^32.
- Output mux:
  - RUN: if_pc = f_pc, if_instr = instr_in, base valid = f_valid.
  - HOLD: if_pc = h_pc, if_instr = h_instr, base valid = h_valid.
  - if_valid = base valid & ~redirect_en. The redirect kills the instruction presented in the same cycle.
- State machine:
  - RUN & stall & ~redirect_en: capture {f_pc, instr_in, f_valid} into the hold buffer; go to HOLD.
  - RUN otherwise: stay in RUN.
  - HOLD & stall & ~redirect_en: stay in HOLD; hold buffer is unchanged.
  - HOLD & ~stall & ~redirect_en: the held word is consumed this cycle; go to RUN.
  - Any state & redirect_en: go to RUN and clear h_valid. redirect_en wins over a simultaneous stall.
  - rst: state <= RUN; h_valid, f_valid <= 0.
- Why the hold buffer is needed: while stalled, pc_q holds the next address N. imem then keeps returning mem[N], and the stalled word is kept only in the hold buffer. Leaving HOLD advances pc_q to N+4. The next cycle RUN presents mem[N] tagged N, so no instruction is skipped or duplicated.
- if_pc4 is always derived from the selected if_pc, 32-bit wrap.
- Don't-care data: while if_valid = 0, if_instr may be X (e.g. imem output during reset). Downstream must qualify on if_valid.

## Timing
- Reset values during and after rst:
  - pc_out = RESET_PC; state RUN; if_valid = 0.
  - if_pc, if_pc4, if_instr are don't-care.
- After rst falls:
  - First cycle: if_valid = 0, pc_out = RESET_PC.
  - Second cycle: if_valid = 1, if_pc = RESET_PC.
- Fetch latency: a PC on pc_out appears on if_pc/if_instr exactly 1 cycle later, absent stall or redirect.
- Throughput: one instruction per cycle when stall = 0.
- Redirect penalty: redirect_en high in cycle c:
  - Cycle c: if_valid = 0 (killed).
  - Cycle c+1: pc_out = target, if_valid = 0.
  - Cycle c+2: if_pc = target, if_valid = 1.
- Stall: if_* stable for every cycle stall is high plus the release cycle. Nothing is lost or repeated.
- rst mid-HOLD or mid-redirect: behaves exactly as a fresh reset; hold contents discarded.

## Test plan
- Reset/sequential: rst high 2 cycles, RESET_PC=0, imem preloaded -> if_valid 0, 0, then if_pc 0x0, 0x4, 0x8 with matching mem words; if_pc4 = if_pc+4.
- Stall: stall high 3 cycles while if_pc=0x8 -> if_pc/if_instr held at 0x8 for 4 cycles, pc_out held at 0xC; the next valid if_pc is 0xC.
- Redirect: redirect_en with redirect_pc=0x40 while if_pc=0x10 -> if_valid 0 that cycle and the next; then if_pc 0x40, 0x44.
- Redirect during HOLD with stall still high -> redirect wins: state RUN, pc_out 0x40 next cycle, if_pc 0x40 two cycles later; old held word never valid.
- Misaligned target: redirect_pc=0x43 -> pc_out 0x40.
- Reset mid-HOLD: rst asserted in stalled HOLD -> pc_out RESET_PC, if_valid 0; fetch restarts at RESET_PC with no trace of the held word.
